adder: RTL and testbench

ADDER -- requirements
Module: adder

---
 rtl/adder.sv | 58 +++++
 tb/tb_adder.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/adder.sv
// adder: WIDTH-bit registered up-counter with synchronous clear and
// increment, optional saturation at all-ones, async active-low reset.
//
// Ports:
//   aclk  - clock, all state updates on the rising edge
//   arstn - asynchronous active-low reset (release must be synchronized)
//   clr   - synchronous clear, wins over inc
//   inc   - synchronous increment request
//   out   - current count, driven straight from the register
module adder #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             aclk,
    input  logic             arstn,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] out
);

    if (WIDTH < 1) begin : g_bad_width
        $error("adder: WIDTH must be at least 1");
    end

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Clear first, then hold on idle, then saturate or wrap on increment.
    function automatic logic [WIDTH-1:0] next_val(
        input logic [WIDTH-1:0] cur,
        input logic             c,
        input logic             i
    );
        if (c) begin
            return '0;
        end
        if (!i) begin
            return cur;
        end
        if (SATURATE && (&cur)) begin
            return cur;
        end
        return cur + WIDTH'(1);
    endfunction

    assign cnt_d = next_val(cnt_q, clr, inc);

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out = cnt_q;

endmodule

// File: tb/tb_adder.sv
// tb_adder: directed, table-driven bench for adder; runs a wrapping and
// a saturating 8-bit instance side by side on the same stimulus.
module tb_adder;

    logic       aclk;
    logic       arstn;
    logic       clr;
    logic       inc;
    logic [7:0] out_w;
    logic [7:0] out_s;

    int checks;
    int passed;

    adder #(.WIDTH(8), .SATURATE(1'b0)) dut_w (
        .aclk (aclk),
        .arstn(arstn),
        .clr  (clr),
        .inc  (inc),
        .out  (out_w)
    );

    adder #(.WIDTH(8), .SATURATE(1'b1)) dut_s (
        .aclk (aclk),
        .arstn(arstn),
        .clr  (clr),
        .inc  (inc),
        .out  (out_s)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic       c;
        logic       i;
        logic [7:0] ew;
        logic [7:0] es;
        string      name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check2(input string name, input logic [7:0] ew,
                          input logic [7:0] es);
        check({name, "/wrap"}, out_w, ew);
        check({name, "/sat"}, out_s, es);
    endtask

    task automatic step(input logic c, input logic i);
        @(negedge aclk);
        clr = c;
        inc = i;
        @(posedge aclk);
        #1;
    endtask

    task automatic add(input logic c, input logic i, input logic [7:0] ew,
                       input logic [7:0] es, input string name);
        vec_t v;
        v.c = c;
        v.i = i;
        v.ew = ew;
        v.es = es;
        v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        passed = 0;
        arstn = 1'b0;
        clr = 1'b0;
        inc = 1'b0;

        repeat (3) add(1'b0, 1'b0, 8'd0, 8'd0, "idle0");
        add(1'b0, 1'b1, 8'd1, 8'd1, "inc1");
        repeat (3) add(1'b0, 1'b0, 8'd1, 8'd1, "hold1");
        for (int k = 2; k <= 10; k++) begin
            add(1'b0, 1'b1, 8'(k), 8'(k), "inc_run");
        end
        add(1'b0, 1'b0, 8'd10, 8'd10, "hold10");
        add(1'b1, 1'b0, 8'd0, 8'd0, "clr10");
        for (int k = 1; k <= 5; k++) begin
            add(1'b0, 1'b1, 8'(k), 8'(k), "inc_to5");
        end
        add(1'b1, 1'b1, 8'd0, 8'd0, "clr_inc_at5");
        add(1'b0, 1'b0, 8'd0, 8'd0, "hold0");

        repeat (5) @(negedge aclk);
        check2("reset_out", 8'd0, 8'd0);
        clr = 1'b1;
        inc = 1'b1;
        @(posedge aclk);
        #1;
        check2("reset_ignores_inputs", 8'd0, 8'd0);
        clr = 1'b0;
        inc = 1'b0;
        while ($time < 100) @(negedge aclk);
        arstn = 1'b1;

        foreach (vecs[n]) begin
            step(vecs[n].c, vecs[n].i);
            check2(vecs[n].name, vecs[n].ew, vecs[n].es);
        end

        repeat (255) step(1'b0, 1'b1);
        check2("reach255", 8'd255, 8'd255);
        step(1'b0, 1'b1);
        check2("inc_at_max", 8'd0, 8'd255);
        step(1'b0, 1'b1);
        check2("inc_after_max", 8'd1, 8'd255);
        step(1'b1, 1'b0);
        check2("clr_after_max", 8'd0, 8'd0);

        repeat (7) step(1'b0, 1'b1);
        check2("count7", 8'd7, 8'd7);
        #2;
        arstn = 1'b0;
        #1;
        check2("async_reset_mid", 8'd0, 8'd0);
        @(negedge aclk);
        inc = 1'b1;
        @(posedge aclk);
        #1;
        check2("reset_holds_inc", 8'd0, 8'd0);
        @(negedge aclk);
        arstn = 1'b1;
        @(posedge aclk);
        #1;
        check2("first_edge_after_rst", 8'd1, 8'd1);
        repeat (4) step(1'b0, 1'b0);
        check2("idle_hold", 8'd1, 8'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
